// File: rtl/int_sequencer.sv
// Interrupt entry sequencer for the pipelined RAT CPU: synchronises irq_in, drains the
// pipeline with injected NOPs, pushes the resume PC and vectors the PC with I cleared.
module int_sequencer #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [9:0] VECTOR      = 10'h3FF,
   parameter int         DRAIN_MAX   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       irq_in,
   input  logic       i_flag,
   input  logic       ex_valid,
   input  logic       wb_valid,
   input  logic       pipe_hold,
   input  logic [9:0] next_pc,
   output logic       fetch_nop,
   output logic       save_we,
   output logic [9:0] save_pc,
   output logic       sp_decr,
   output logic       pc_force_ld,
   output logic [9:0] vec_addr,
   output logic       i_clr,
   output logic       irq_pending,
   output logic       busy,
   output logic       drain_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_SAVE,
      S_VEC,
      S_RESUME
   } state_t;

   localparam logic [3:0] DRAIN_LIMIT = 4'(DRAIN_MAX);

   state_t                 state;
   state_t                 state_nx;
   logic [SYNC_STAGES-1:0] sync_p;
   logic                   edge_q;
   logic                   irq_rise;
   logic [3:0]             cnt;
   logic [3:0]             cnt_inc;
   logic                   pipe_empty;

   assign irq_rise   = sync_p[SYNC_STAGES-1] & ~edge_q;
   assign cnt_inc    = (cnt == 4'hF) ? cnt : cnt + 4'd1;
   assign pipe_empty = ~ex_valid & ~wb_valid & ~pipe_hold;
   assign vec_addr   = VECTOR;

   // Synchroniser and edge detect: only a rising edge of the synced level raises a request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_p <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_p <= {sync_p[SYNC_STAGES-2:0], irq_in};
         edge_q <= sync_p[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         irq_pending <= 1'b0;
         save_pc     <= '0;
         cnt         <= '0;
         drain_err   <= 1'b0;
      end else begin
         state       <= state_nx;
         // A new edge in the VECTOR cycle must survive the clear.
         irq_pending <= irq_rise | (irq_pending & (state != S_VEC));
         if (state == S_DRAIN) begin
            cnt <= cnt_inc;
            if (cnt_inc >= DRAIN_LIMIT) drain_err <= 1'b1;
            // Sampled at exit so a branch resolving mid-drain is honoured.
            if (pipe_empty) save_pc <= next_pc;
         end else if (state == S_RESUME) begin
            cnt <= '0;
         end
      end
   end

   always_comb begin
      state_nx    = state;
      fetch_nop   = 1'b0;
      save_we     = 1'b0;
      sp_decr     = 1'b0;
      pc_force_ld = 1'b0;
      i_clr       = 1'b0;
      busy        = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (irq_pending && i_flag) state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            fetch_nop = 1'b1;
            busy      = 1'b1;
            if (pipe_empty) state_nx = S_SAVE;
         end
         S_SAVE: begin
            fetch_nop = 1'b1;
            busy      = 1'b1;
            save_we   = 1'b1;
            sp_decr   = 1'b1;
            state_nx  = S_VEC;
         end
         S_VEC: begin
            fetch_nop   = 1'b1;
            busy        = 1'b1;
            pc_force_ld = 1'b1;
            i_clr       = 1'b1;
            state_nx    = S_RESUME;
         end
         S_RESUME: begin
            fetch_nop = 1'b1;
            busy      = 1'b1;
            state_nx  = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: vector table, directed corner sequences and a random run
// checked against a cycle-level behavioural model of the entry protocol.
module tb_int_sequencer;

   localparam int S  = 2;
   localparam int DM = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       irq_in, i_flag, ex_valid, wb_valid, pipe_hold;
   logic [9:0] next_pc;
   logic       fetch_nop, save_we, sp_decr, pc_force_ld, i_clr, irq_pending, busy, drain_err;
   logic [9:0] save_pc, vec_addr;

   int checks = 0;
   int errors = 0;

   int_sequencer #(.SYNC_STAGES(S), .VECTOR(10'h3FF), .DRAIN_MAX(DM)) dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .i_flag(i_flag), .ex_valid(ex_valid),
      .wb_valid(wb_valid), .pipe_hold(pipe_hold), .next_pc(next_pc), .fetch_nop(fetch_nop),
      .save_we(save_we), .save_pc(save_pc), .sp_decr(sp_decr), .pc_force_ld(pc_force_ld),
      .vec_addr(vec_addr), .i_clr(i_clr), .irq_pending(irq_pending), .busy(busy),
      .drain_err(drain_err)
   );

   always #5 clk = ~clk;

   // Reference model: irq history, a drain flag, and a countdown over SAVE/VECTOR/RESUME.
   bit       m_hist[0:S];
   bit       m_pend, m_drain, m_err;
   int       m_tail, m_cnt;
   bit [9:0] m_spc;

   task automatic model_reset();
      for (int i = 0; i <= S; i++) m_hist[i] = 1'b0;
      m_pend = 0; m_drain = 0; m_err = 0; m_tail = 0; m_cnt = 0; m_spc = '0;
   endtask

   task automatic model_step();
      bit rise, in_vector;
      rise      = m_hist[S-1] && !m_hist[S];
      in_vector = (m_tail == 2);
      if (m_tail > 0) begin
         if (m_tail == 1) m_cnt = 0;
         m_tail--;
      end else if (m_drain) begin
         m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
         if (m_cnt >= DM) m_err = 1;
         if (!ex_valid && !wb_valid && !pipe_hold) begin
            m_drain = 0;
            m_tail  = 3;
            m_spc   = next_pc;
         end
      end else if (m_pend && i_flag) begin
         m_drain = 1;
      end
      m_pend = rise || (m_pend && !in_vector);
      for (int i = S; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = irq_in;
   endtask

   function automatic logic [27:0] model_outs();
      bit b;
      b = m_drain || (m_tail > 0);
      return {b, m_tail == 3, m_tail == 3, m_tail == 2, m_tail == 2, m_pend, b, m_err,
              m_spc, 10'h3FF};
   endfunction

   function automatic logic [27:0] dut_outs();
      return {fetch_nop, save_we, sp_decr, pc_force_ld, i_clr, irq_pending, busy, drain_err,
              save_pc, vec_addr};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
      end
   endtask

   // One clock: model advances on the same edge; outputs sampled 1 time unit later.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("model", 32'(dut_outs()), 32'(model_outs()));
   endtask

   task automatic tick();
      cycle();
      @(negedge clk);
   endtask

   task automatic do_reset();
      irq_in = 0; i_flag = 0; ex_valid = 0; wb_valid = 0; pipe_hold = 0; next_pc = '0;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   typedef struct {
      logic       irq;
      logic       ifl;
      logic [9:0] npc;
      logic       e_busy;
      logic       e_pend;
      logic       e_save;
      logic       e_force;
      logic [9:0] e_spc;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{1, 1, 10'h045, 0, 0, 0, 0, 10'h000};
      tbl[1] = '{1, 1, 10'h045, 0, 0, 0, 0, 10'h000};
      tbl[2] = '{1, 1, 10'h045, 0, 1, 0, 0, 10'h000};
      tbl[3] = '{1, 1, 10'h045, 1, 1, 0, 0, 10'h000};
      tbl[4] = '{1, 1, 10'h045, 1, 1, 1, 0, 10'h045};
      tbl[5] = '{1, 1, 10'h045, 1, 1, 0, 1, 10'h045};
      tbl[6] = '{1, 1, 10'h045, 1, 0, 0, 0, 10'h045};
      tbl[7] = '{1, 1, 10'h045, 0, 0, 0, 0, 10'h045};

      irq_in = 0; i_flag = 0; ex_valid = 0; wb_valid = 0; pipe_hold = 0; next_pc = '0;
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", 32'({fetch_nop, save_we, sp_decr, pc_force_ld, i_clr, irq_pending,
                              busy, drain_err, save_pc}), 32'd0);
      chk("reset_vec", 32'(vec_addr), 32'h3FF);
      @(negedge clk);
      rst = 1'b1;

      // Basic entry with an empty pipe.
      for (int i = 0; i < 8; i++) begin
         irq_in = tbl[i].irq; i_flag = tbl[i].ifl; next_pc = tbl[i].npc;
         cycle();
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
         chk($sformatf("tbl%0d_pend", i), 32'(irq_pending), 32'(tbl[i].e_pend));
         chk($sformatf("tbl%0d_save", i), 32'({save_we, sp_decr}), 32'({2{tbl[i].e_save}}));
         chk($sformatf("tbl%0d_force", i), 32'({pc_force_ld, i_clr}), 32'({2{tbl[i].e_force}}));
         chk($sformatf("tbl%0d_spc", i), 32'(save_pc), 32'(tbl[i].e_spc));
         @(negedge clk);
      end

      // I masked: request stays pending until I is raised.
      do_reset();
      for (int e = 1; e <= 13; e++) begin
         irq_in = (e == 1);
         i_flag = (e >= 9);
         cycle();
         if (e == 8) begin
            chk("mask_pend", 32'(irq_pending), 32'd1);
            chk("mask_busy", 32'(busy), 32'd0);
         end
         if (e == 9)  chk("unmask_start", 32'(busy), 32'd1);
         if (e == 13) chk("unmask_done", 32'({busy, irq_pending}), 32'd0);
         @(negedge clk);
      end

      // Branch resolving during drain: resume PC taken at drain exit.
      do_reset();
      for (int e = 1; e <= 9; e++) begin
         irq_in = 1; i_flag = 1;
         ex_valid = (e <= 6);
         next_pc  = (e >= 6) ? 10'h120 : 10'h010;
         cycle();
         if (e == 6) chk("branch_still_drain", 32'({busy, save_we}), 32'b10);
         if (e == 7) begin
            chk("branch_save_we", 32'(save_we), 32'd1);
            chk("branch_save_pc", 32'(save_pc), 32'h120);
         end
         @(negedge clk);
      end
      ex_valid = 0;

      // Long stall: drain_err goes sticky, sequence still completes.
      do_reset();
      for (int e = 1; e <= 19; e++) begin
         irq_in = 1; i_flag = 1;
         pipe_hold = (e <= 14);
         cycle();
         if (e == 11) chk("drain_err_early", 32'(drain_err), 32'd0);
         if (e == 12) chk("drain_err_set", 32'(drain_err), 32'd1);
         if (e == 15) chk("drain_late_save", 32'(save_we), 32'd1);
         if (e == 19) chk("drain_err_sticky", 32'({drain_err, busy}), 32'b10);
         @(negedge clk);
      end

      // Asynchronous reset in SAVE and in VECTOR.
      for (int tgt = 5; tgt <= 6; tgt++) begin
         do_reset();
         for (int e = 1; e <= tgt; e++) begin
            irq_in = 1; i_flag = 1;
            cycle();
            if (e < tgt) @(negedge clk);
         end
         chk($sformatf("pre_rst%0d", tgt), 32'({save_we, pc_force_ld}),
             (tgt == 5) ? 32'b10 : 32'b01);
         #2;
         rst = 1'b0;
         model_reset();
         #1;
         chk($sformatf("async_rst%0d", tgt),
             32'({save_we, pc_force_ld, busy, irq_pending, fetch_nop}), 32'd0);
         @(negedge clk);
         irq_in = 0;
         rst = 1'b1;
      end

      // Random traffic against the model, with one asynchronous reset mid-run.
      do_reset();
      i_flag = 1;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(7) == 0) irq_in = ~irq_in;
         if ($urandom_range(15) == 0) i_flag = ~i_flag;
         ex_valid  = ($urandom_range(3) == 0);
         wb_valid  = ($urandom_range(3) == 0);
         pipe_hold = ($urandom_range(3) == 0);
         next_pc   = 10'($urandom);
         if (n == 2000) begin
            #2;
            rst = 1'b0;
            model_reset();
            #1;
            chk("rand_async_rst", 32'(dut_outs()), 32'(model_outs()));
            @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
